// File: rtl/sn_gen_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// sn_arb_pkg
// Shared types and constants for the stochastic-number generator arbiter.
//   sn_arb_state_e : scheduler FSM states
//   SN_STREAM_LEN  : nominal bitstream length of the shared generator
//   SN_CNT_W       : width of the stream-length counter (saturates at 31)
//   sn_operand_t   : one generator operand, four 4-bit values
// ----------------------------------------------------------------------------
package sn_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_WAIT_GEN = 3'd2,
        ST_RUN      = 3'd3,
        ST_STOP     = 3'd4,
        ST_DONE     = 3'd5
    } sn_arb_state_e;

    localparam int SN_STREAM_LEN = 16;
    localparam int SN_CNT_W      = 5;

    typedef logic [3:0][3:0] sn_operand_t;

endpackage

// File: rtl/sn_gen_arbiter_if.sv
// ----------------------------------------------------------------------------
// sn_gen_arbiter_if
// Bundles the requester side and the generator side of the arbiter.
//   Requesters : i_req_valid, i_req_x_bn -> o_req_ready (one-hot accept)
//   Control    : i_abort
//   Generator  : o_gen_x_bn, o_gen_start, o_gen_stop <- i_gen_isgen
//   Completion : o_done, o_done_id, o_done_len, o_done_abort, o_err
//   Status     : o_busy, o_dbg_state (current FSM state)
// Handshake: a job is transferred in the cycle where i_req_valid[n] and
// o_req_ready[n] are both high; a requester keeps valid and its operand
// stable until then and may withdraw valid at any time before.
// modport slave is taken by the arbiter, modport master by its environment.
// ----------------------------------------------------------------------------
interface sn_gen_arbiter_if
    import sn_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) ();
    localparam int ID_W = $clog2(NUM_REQ);

    logic        [NUM_REQ-1:0] i_req_valid;
    sn_operand_t [NUM_REQ-1:0] i_req_x_bn;
    logic        [NUM_REQ-1:0] o_req_ready;
    logic                      i_abort;
    sn_operand_t               o_gen_x_bn;
    logic                      o_gen_start;
    logic                      o_gen_stop;
    logic                      i_gen_isgen;
    logic                      o_done;
    logic        [ID_W-1:0]    o_done_id;
    logic        [SN_CNT_W-1:0] o_done_len;
    logic                      o_done_abort;
    logic                      o_err;
    logic                      o_busy;
    sn_arb_state_e             o_dbg_state;

    modport slave (
        input  i_req_valid, i_req_x_bn, i_abort, i_gen_isgen,
        output o_req_ready, o_gen_x_bn, o_gen_start, o_gen_stop,
               o_done, o_done_id, o_done_len, o_done_abort, o_err,
               o_busy, o_dbg_state
    );

    modport master (
        output i_req_valid, i_req_x_bn, i_abort, i_gen_isgen,
        input  o_req_ready, o_gen_x_bn, o_gen_start, o_gen_stop,
               o_done, o_done_id, o_done_len, o_done_abort, o_err,
               o_busy, o_dbg_state
    );

endinterface

// File: rtl/sn_gen_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational circular priority encoder: picks the first set bit of
// valid_i at or after ptr_i, wrapping around.
//   valid_i [NUM_REQ] : request bits
//   ptr_i   [ID_W]    : search start position (must be < NUM_REQ)
//   grant_o [NUM_REQ] : one-hot winner (zero when nothing is valid)
//   id_o    [ID_W]    : binary winner index
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    id_o
);
    localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

    logic            found;
    logic [ID_W:0]   idx;

    always_comb begin
        grant_o = '0;
        id_o    = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // ptr + i stays below 2*NUM_REQ, so one subtraction wraps it.
            idx = {1'b0, ptr_i} + (ID_W+1)'(i);
            if (idx >= NUM_REQ_W) idx = idx - NUM_REQ_W;
            if (!found && valid_i[idx[ID_W-1:0]]) begin
                found                  = 1'b1;
                grant_o[idx[ID_W-1:0]] = 1'b1;
                id_o                   = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sn_gen_arbiter.sv
// ----------------------------------------------------------------------------
// sn_gen_arbiter
// Round-robin scheduler sharing one stochastic-number generator among
// NUM_REQ layer units. Accepts a job, latches its operand, pulses the
// generator start, counts the cycles the generator reports busy and returns
// a tagged completion pulse. Supports abort (stop pulse) mid-stream.
//   i_clk_sn_arb : clock
//   i_rst_sn_arb : synchronous active-high reset
//   bus          : sn_gen_arbiter_if.slave (requests, generator, completion)
// Optional feature: define SN_ARB_TIMEOUT_EN to give up on a generator that
// does not raise busy within TIMEOUT cycles of start (o_err pulse).
// ----------------------------------------------------------------------------
module sn_gen_arbiter
    import sn_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int STREAM_LEN = SN_STREAM_LEN,
    parameter int TIMEOUT    = 4
) (
    input  logic             i_clk_sn_arb,
    input  logic             i_rst_sn_arb,
    sn_gen_arbiter_if.slave  bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || STREAM_LEN < 1 || STREAM_LEN > 31 || TIMEOUT < 1) begin : g_cfg_err
        $error("sn_gen_arbiter: unsupported parameter set");
    end

    sn_arb_state_e        state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]      id_q, id_d;
    sn_operand_t          x_q, x_d;
    logic [SN_CNT_W-1:0]  cnt_q, cnt_d;
    logic                 abort_q, abort_d;
    logic                 stop_q, stop_d;
    logic [NUM_REQ-1:0]   pick_grant;
    logic [ID_W-1:0]      pick_id;
    logic [NUM_REQ-1:0]   req_ready;

`ifdef SN_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic                 err_q, err_d;
`endif

    rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .valid_i (bus.i_req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .id_o    (pick_id)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        id_d      = id_q;
        x_d       = x_q;
        cnt_d     = cnt_q;
        abort_d   = abort_q;
        stop_d    = 1'b0;
        req_ready = '0;
`ifdef SN_ARB_TIMEOUT_EN
        tmo_d     = tmo_q;
        err_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|bus.i_req_valid) begin
                    req_ready = pick_grant;
                    x_d       = bus.i_req_x_bn[pick_id];
                    id_d      = pick_id;
                    abort_d   = 1'b0;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = '0;
`ifdef SN_ARB_TIMEOUT_EN
                tmo_d   = '0;
`endif
                state_d = ST_WAIT_GEN;
            end
            ST_WAIT_GEN: begin
                if (bus.i_abort) begin
                    stop_d  = 1'b1;
                    abort_d = 1'b1;
                    state_d = ST_STOP;
                end else if (bus.i_gen_isgen) begin
                    cnt_d   = SN_CNT_W'(1);
                    state_d = ST_RUN;
                end
`ifdef SN_ARB_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    // Generator never came up: stop it and close the job
                    // through STOP, which sees busy low and moves on.
                    stop_d  = 1'b1;
                    err_d   = 1'b1;
                    abort_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_STOP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            ST_RUN: begin
                // The abort cycle still counts a busy cycle.
                if (bus.i_gen_isgen && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
                if (bus.i_abort) begin
                    stop_d  = 1'b1;
                    abort_d = 1'b1;
                    state_d = ST_STOP;
                end else if (!bus.i_gen_isgen) begin
                    state_d = ST_DONE;
                end
            end
            ST_STOP: begin
                if (!bus.i_gen_isgen) state_d = ST_DONE;
            end
            ST_DONE: begin
                rr_ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_sn_arb) begin
        if (i_rst_sn_arb) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            x_q      <= '0;
            cnt_q    <= '0;
            abort_q  <= 1'b0;
            stop_q   <= 1'b0;
`ifdef SN_ARB_TIMEOUT_EN
            tmo_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            x_q      <= x_d;
            cnt_q    <= cnt_d;
            abort_q  <= abort_d;
            stop_q   <= stop_d;
`ifdef SN_ARB_TIMEOUT_EN
            tmo_q    <= tmo_d;
            err_q    <= err_d;
`endif
        end
    end

    // Completion fields are only meaningful during the DONE pulse and read
    // as zero otherwise.
    assign bus.o_req_ready  = req_ready;
    assign bus.o_gen_x_bn   = x_q;
    assign bus.o_gen_start  = (state_q == ST_LOAD);
    assign bus.o_gen_stop   = stop_q;
    assign bus.o_done       = (state_q == ST_DONE);
    assign bus.o_done_id    = (state_q == ST_DONE) ? id_q : '0;
    assign bus.o_done_len   = (state_q == ST_DONE) ? cnt_q : '0;
    assign bus.o_done_abort = (state_q == ST_DONE) && abort_q;
    assign bus.o_busy       = (state_q != ST_IDLE);
    assign bus.o_dbg_state  = state_q;
`ifdef SN_ARB_TIMEOUT_EN
    assign bus.o_err        = err_q;
`else
    assign bus.o_err        = 1'b0;
`endif

endmodule
